// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with interrupt request.
// Ports: clk, reset (async high), addr/we/wdata (store path), rdata (load path), irq.
// Map addr[3:2]: 00 CTRL {IM,MODE[1:0],EN}, 01 PRESET, 10 COUNT (RO), 11 reserved.
// Optional macro TC_AUTORELOAD_EN: stores MODE and enables MODE=01 auto-reload.
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  logic        r_en;
  logic        r_im;
  logic        r_flag;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [1:0]  w_mode;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_unused;

`ifdef TC_AUTORELOAD_EN
  logic [1:0]  r_mode;
  logic        w_auto;
  assign w_mode = r_mode;
  assign w_auto = (r_mode == 2'b01);
`else
  assign w_mode = 2'b00;
`endif

  assign w_wr_ctrl = we && (addr[3:2] == 2'b00);
  assign w_wr_pre  = we && (addr[3:2] == 2'b01);
  assign w_unused  = &{1'b0, addr[31:4], addr[1:0]};

  // FSM updates follow the CPU write so a flag set in the
  // same cycle overrides the write-side flag clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_en     <= 1'b0;
      r_im     <= 1'b0;
      r_flag   <= 1'b0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
`ifdef TC_AUTORELOAD_EN
      r_mode   <= 2'b00;
`endif
    end else begin
      if (w_wr_ctrl) begin
        r_en <= wdata[0];
        r_im <= wdata[3];
`ifdef TC_AUTORELOAD_EN
        r_mode <= wdata[2:1];
`endif
      end
      if (w_wr_pre) begin
        r_preset <= wdata;
      end
      if (w_wr_ctrl || w_wr_pre) begin
        r_flag <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_en) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= r_en ? S_CNT : S_IDLE;
        end
        S_CNT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else if (r_count == 32'd0) begin
            r_state <= S_INT;
            r_flag  <= 1'b1;
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        S_INT: begin
`ifdef TC_AUTORELOAD_EN
          if (w_auto) begin
            r_flag  <= 1'b0;
            r_state <= S_LOAD;
          end else begin
            // a simultaneous CPU CTRL write keeps its EN value
            if (!w_wr_ctrl) begin
              r_en <= 1'b0;
            end
            r_state <= S_IDLE;
          end
`else
          if (!w_wr_ctrl) begin
            r_en <= 1'b0;
          end
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'b00:   rdata = {28'd0, r_im, w_mode, r_en};
      2'b01:   rdata = r_preset;
      2'b10:   rdata = r_count;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = r_flag & r_im;

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed vector table plus hand-written
// sequences for multi-cycle corner cases of tc_timer.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_pass = 0;
  int n_tot  = 0;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [31:0] erd;
    logic        eirq;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick(input logic w, input logic [3:0] a,
                      input logic [31:0] d);
    we    = w;
    addr  = {28'd0, a};
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                    input string nm);
    addr = {28'd0, a};
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic ck_irq(input logic exp, input string nm);
    chk(nm, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    we    = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // one-shot run with PRESET=3, then register-map corners
    v[0]  = '{1'b1, 4'h4, 32'd3,          4'h4, 32'd3, 1'b0};
    v[1]  = '{1'b1, 4'h0, 32'h9,          4'h0, 32'h9, 1'b0};
    v[2]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd0, 1'b0};
    v[3]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd3, 1'b0};
    v[4]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd2, 1'b0};
    v[5]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd1, 1'b0};
    v[6]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd0, 1'b0};
    v[7]  = '{1'b0, 4'h0, 32'd0,          4'h8, 32'd0, 1'b1};
    v[8]  = '{1'b0, 4'h0, 32'd0,          4'h0, 32'h8, 1'b1};
    v[9]  = '{1'b0, 4'h0, 32'd0,          4'h0, 32'h8, 1'b1};
    v[10] = '{1'b1, 4'h0, 32'h8,          4'h0, 32'h8, 1'b0};
    v[11] = '{1'b1, 4'h8, 32'h55,         4'h8, 32'd0, 1'b0};
    v[12] = '{1'b1, 4'hC, 32'hFF,         4'hC, 32'd0, 1'b0};
    v[13] = '{1'b0, 4'h0, 32'd0,          4'h4, 32'd3, 1'b0};
    v[14] = '{1'b1, 4'h0, 32'hFFFF_FFF0,  4'h0, 32'd0, 1'b0};

    // reset held: all addresses read 0
    #2;
    rd(4'h0, 32'd0, "rst_ctrl");
    rd(4'h4, 32'd0, "rst_preset");
    rd(4'h8, 32'd0, "rst_count");
    rd(4'hC, 32'd0, "rst_rsv");
    ck_irq(1'b0, "rst_irq");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      tick(v[i].we, v[i].wa, v[i].wd);
      rd(v[i].ra, v[i].erd, $sformatf("vec%0d_rdata", i));
      ck_irq(v[i].eirq, $sformatf("vec%0d_irq", i));
    end

    // auto-reload request: PRESET=2, CTRL=0xB
    do_reset();
    tick(1'b1, 4'h4, 32'd2);
    tick(1'b1, 4'h0, 32'hB);
`ifdef TC_AUTORELOAD_EN
    rd(4'h0, 32'hB, "ar_ctrl");
    for (int k = 1; k <= 16; k++) begin
      logic e;
      e = (k >= 5) && ((k % 5) == 0);
      idle();
      ck_irq(e, $sformatf("ar_irq_e%0d", k));
    end
`else
    rd(4'h0, 32'h9, "ar_off_ctrl");
    for (int k = 1; k <= 8; k++) begin
      idle();
      ck_irq(k >= 5, $sformatf("ar_off_irq_e%0d", k));
    end
    rd(4'h0, 32'h8, "ar_off_ctrl_end");
`endif

    // disable mid-count, then re-enable reloads
    do_reset();
    tick(1'b1, 4'h4, 32'd10);
    tick(1'b1, 4'h0, 32'h9);
    repeat (5) idle();
    rd(4'h8, 32'd7, "dis_pre");
    tick(1'b1, 4'h0, 32'h8);
    rd(4'h8, 32'd6, "dis_at");
    repeat (3) idle();
    rd(4'h8, 32'd6, "dis_hold");
    ck_irq(1'b0, "dis_irq");
    tick(1'b1, 4'h0, 32'h9);
    idle();
    rd(4'h8, 32'd6, "reen_load");
    idle();
    rd(4'h8, 32'd10, "reen_cnt");

    // PRESET=0, write collisions with flag set and INT
    do_reset();
    tick(1'b1, 4'h4, 32'd0);
    tick(1'b1, 4'h0, 32'h9);
    idle();
    idle();
    ck_irq(1'b0, "p0_e2");
    tick(1'b1, 4'h0, 32'h9);
    ck_irq(1'b1, "p0_setwins");
    tick(1'b1, 4'h0, 32'h9);
    rd(4'h0, 32'h9, "int_cpuwins");
    ck_irq(1'b0, "int_wrclr");
    idle();
    idle();
    ck_irq(1'b0, "p0_again_e6");
    idle();
    ck_irq(1'b1, "p0_again_e7");

    // PRESET write during a count from 10
    do_reset();
    tick(1'b1, 4'h4, 32'd10);
    tick(1'b1, 4'h0, 32'h9);
    for (int k = 1; k <= 13; k++) begin
      if (k == 5) tick(1'b1, 4'h4, 32'd5);
      else idle();
      if (k == 5) rd(4'h8, 32'd7, "pw_count");
      if (k == 12) ck_irq(1'b0, "pw_e12");
      if (k == 13) ck_irq(1'b1, "pw_e13");
    end
    rd(4'h4, 32'd5, "pw_preset");

    // async reset between edges with irq=1
    do_reset();
    tick(1'b1, 4'h4, 32'd3);
    tick(1'b1, 4'h0, 32'h9);
    repeat (6) idle();
    ck_irq(1'b1, "ar_pre_irq");
    #2;
    reset = 1'b1;
    #1;
    ck_irq(1'b0, "arst_irq");
    rd(4'h8, 32'd0, "arst_count");
    rd(4'h0, 32'd0, "arst_ctrl");
    rd(4'h4, 32'd0, "arst_preset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) idle();
    ck_irq(1'b0, "post_rst_irq");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped countdown timer for the pipelined MIPS core. It is the responder on the core's data-memory store/load path: the core writes and reads its three registers through word-wide accesses and receives an interrupt request back. The block sits behind the address decoder alongside data memory. It counts down from a preset value and raises `irq` on expiry, either once or periodically.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `addr` in 32: byte address; only `addr[3:2]` is decoded, and the upstream decoder qualifies the chip select into `we`.
- `we` in 1: write strobe for this device, sampled at the rising edge.
- `wdata` in 32: store data.
- `rdata` out 32: combinational read data selected by `addr[3:2]`.
- `irq` out 1: interrupt request, equal to the internal flag AND `CTRL.IM`.

## Operation
- Register map (`addr[3:2]`):
  - 00 `CTRL`: bit0 `EN`, bits2:1 `MODE`, bit3 `IM`; bits 31:4 read as 0.
  - 01 `PRESET`: 32-bit reload value.
  - 10 `COUNT`: read-only; writes are ignored.
  - 11: reads 0; writes are ignored.
- Writes:
  - A write to `CTRL` stores `wdata[3:0]`.
  - A write to `PRESET` stores all 32 bits.
  - A write to `CTRL` or `PRESET` also clears the interrupt flag.
- `MODE` decoding: 01 is auto-reload; 00, 10 and 11 are one-shot.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if `EN` → LOAD, else stay.
  - LOAD: `COUNT` ← `PRESET`. If `EN` → CNT, else → IDLE.
  - CNT:
    - `EN`=0 → IDLE, `COUNT` holds.
    - `COUNT`==0 → INT and flag ← 1.
    - Otherwise `COUNT` ← `COUNT`−1.
  - INT, one-shot: `EN` ← 0 and → IDLE; the flag stays set until the next write to `CTRL` or `PRESET`.
  - INT, auto-reload: flag ← 0 and → LOAD, giving a one-cycle flag pulse.
- Re-enabling after a disable always reloads from `PRESET`; counting never resumes from the held value.
- Arithmetic is unsigned 32-bit. `COUNT` never decrements below 0.

## Timing
- Reset values: `CTRL`=0, `PRESET`=0, `COUNT`=0, state IDLE, flag 0, `irq`=0. `rdata` reads 0 for every address while reset is held.
- Reads are zero-latency and combinational; writes become visible after the capturing edge.
- Latency: with `EN` written at edge E0, LOAD occurs at E1, `COUNT`=`PRESET` after E2, and `irq` rises after edge E0+`PRESET`+3.
- Auto-reload period: `PRESET`+3 cycles between successive `irq` pulses.
- `PRESET`=0: INT is entered on the edge after LOAD, so `irq` rises after E0+3.
- Simultaneous events:
  - A CPU write to `CTRL` in the same cycle as the FSM clearing `EN` in INT: the CPU write wins.
  - A CPU write to `CTRL`/`PRESET` in the same cycle the flag is set: the flag set wins.
- A `PRESET` write during CNT does not alter `COUNT` until the next LOAD.
- Reset asserted mid-count returns every output to its reset value immediately, with no clock edge required.

## Configuration
- `TC_AUTORELOAD_EN` defined: `MODE` is stored, and `MODE`=01 selects auto-reload as described above.
- `TC_AUTORELOAD_EN` undefined:
  - `CTRL[2:1]` is never stored and always reads 0.
  - Every run is one-shot and the LOAD-from-INT path is not synthesized.

## Test plan
- Reset, then read all four addresses → `rdata` is 0 each time; `irq`=0.
- One-shot: write `PRESET`=3, then `CTRL`=0x9 at edge E0 → `COUNT` reads 3,2,1,0 after E2..E5; `irq`=1 after E6. `CTRL` reads 0x8 after E7, and `irq` stays 1 until a `CTRL` write of 0x8, which drops it after that edge.
- Auto-reload (macro on): `PRESET`=2, `CTRL`=0xB → `irq` is a one-cycle pulse every 5 cycles over at least 3 periods. With the macro off, the same write gives a single latched `irq` and `CTRL` reads 0x8.
- Disable mid-count: `PRESET`=10, enable, then write `CTRL`=0x8 when `COUNT`=6 → `COUNT` holds at 6 and `irq`=0. Re-enable → `COUNT` reloads to 10.
- Edge cases:
  - `PRESET`=0 with `CTRL`=0x9 → `irq` rises 3 edges after the enabling write.
  - A `PRESET` write of 5 during a count from 10 → the current run still expires from 10.
  - Writes to `COUNT` and to `addr[3:2]`=11 have no effect.
- Asynchronous reset asserted between edges mid-count with `irq`=1 → `irq`, `COUNT` and `CTRL` are 0 before the next rising edge.
